// File: rtl/core_lsu.sv
// Load/store unit: turns one EX-stage memory op into a single data-bus transaction and aligns load data for writeback.
// Optional feature: define KAYRV32_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of forcing alignment.
module core_lsu (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    input  logic        i_Load,
    input  logic        i_Store,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_StoreData,
    input  logic [31:0] i_AluData,
    input  logic [4:0]  i_RdAddr,
    input  logic        i_WriteEn,
    input  logic        i_FlushEn,
    output logic [31:0] o_dMem_Addr,
    output logic [31:0] o_dMem_DataWrite,
    output logic [3:0]  o_dMem_ByteEn,
    output logic        o_dMem_ReadEn,
    output logic        o_dMem_WriteEn,
    input  logic [31:0] i_dMem_DataRead,
    input  logic        i_dMem_Ready,
    output logic        o_WbEn,
    output logic [4:0]  o_WbAddr,
    output logic [31:0] o_WbData,
    output logic        o_StallEn,
    output logic        o_Exception,
    output logic [1:0]  o_ExcCause,
    output logic [31:0] o_ExcAddr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL        = 2'b11;

    state_t      state;

    logic [2:0]  pend_f3;
    logic [1:0]  pend_off;
    logic [4:0]  pend_rd;
    logic        pend_wb;

    logic        is_mem;
    logic        illegal_op;
    logic        misaligned;
    logic        exc_raise;
    logic [1:0]  exc_cause;
    logic [1:0]  lane_off;
    logic [3:0]  byte_en;
    logic [31:0] store_word;

    // Pick the addressed byte or halfword out of a bus word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        is_mem     = i_Load | i_Store;
        illegal_op = (i_Load & i_Store)
                   | (i_Load  & ((i_Funct3 == 3'b011) | (i_Funct3[2:1] == 2'b11)))
                   | (i_Store & (i_Funct3[2] | (i_Funct3[1:0] == 2'b11)));

`ifdef KAYRV32_MISALIGN_TRAP_EN
        misaligned = ((i_Funct3[1:0] == 2'b01) & i_Addr[0])
                   | ((i_Funct3[1:0] == 2'b10) & (i_Addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        exc_raise = illegal_op | misaligned;
        if (illegal_op)
            exc_cause = CAUSE_ILLEGAL;
        else if (i_Load)
            exc_cause = CAUSE_LOAD_MISALIGN;
        else
            exc_cause = CAUSE_STORE_MISALIGN;

        // Without the trap, misaligned low bits are simply dropped to the access size.
        case (i_Funct3[1:0])
            2'b00:   lane_off = i_Addr[1:0];
            2'b01:   lane_off = {i_Addr[1], 1'b0};
            default: lane_off = 2'b00;
        endcase

        case (i_Funct3[1:0])
            2'b00:   byte_en = 4'b0001 << lane_off;
            2'b01:   byte_en = lane_off[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase

        case (i_Funct3[1:0])
            2'b00:   store_word = {4{i_StoreData[7:0]}};
            2'b01:   store_word = {2{i_StoreData[15:0]}};
            default: store_word = i_StoreData;
        endcase
    end

    assign o_StallEn = (state == BUSY);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state            <= IDLE;
            o_dMem_Addr      <= 32'h0;
            o_dMem_DataWrite <= 32'h0;
            o_dMem_ByteEn    <= 4'h0;
            o_dMem_ReadEn    <= 1'b0;
            o_dMem_WriteEn   <= 1'b0;
            o_WbEn           <= 1'b0;
            o_WbAddr         <= 5'h0;
            o_WbData         <= 32'h0;
            o_Exception      <= 1'b0;
            o_ExcCause       <= 2'b00;
            o_ExcAddr        <= 32'h0;
            pend_f3          <= 3'b000;
            pend_off         <= 2'b00;
            pend_rd          <= 5'h0;
            pend_wb          <= 1'b0;
        end else begin
            o_WbEn      <= 1'b0;
            o_Exception <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Valid && !i_FlushEn) begin
                        if (is_mem && exc_raise) begin
                            o_Exception <= 1'b1;
                            o_ExcCause  <= exc_cause;
                            o_ExcAddr   <= i_Addr;
                        end else if (is_mem) begin
                            state            <= BUSY;
                            o_dMem_Addr      <= {i_Addr[31:2], 2'b00};
                            o_dMem_DataWrite <= i_Store ? store_word : 32'h0;
                            o_dMem_ByteEn    <= byte_en;
                            o_dMem_ReadEn    <= i_Load;
                            o_dMem_WriteEn   <= i_Store;
                            pend_f3          <= i_Funct3;
                            pend_off         <= lane_off;
                            pend_rd          <= i_RdAddr;
                            pend_wb          <= i_Load && (i_RdAddr != 5'd0);
                        end else begin
                            o_WbEn   <= i_WriteEn && (i_RdAddr != 5'd0);
                            o_WbAddr <= i_RdAddr;
                            o_WbData <= i_AluData;
                        end
                    end
                end
                BUSY: begin
                    // A flush cannot cancel the bus cycle already issued, only its writeback.
                    if (i_FlushEn)
                        pend_wb <= 1'b0;
                    if (i_dMem_Ready) begin
                        state          <= IDLE;
                        o_dMem_ReadEn  <= 1'b0;
                        o_dMem_WriteEn <= 1'b0;
                        o_WbEn         <= pend_wb && !i_FlushEn;
                        if (o_dMem_ReadEn) begin
                            o_WbAddr <= pend_rd;
                            o_WbData <= load_extract(i_dMem_DataRead, pend_off, pend_f3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: table of transactions through a scoreboard plus reset/flush sequences.
module tb_core_lsu;

    localparam int KIND_ALU = 0;
    localparam int KIND_MEM = 1;
    localparam int KIND_EXC = 2;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_Valid;
    logic        i_Load;
    logic        i_Store;
    logic [2:0]  i_Funct3;
    logic [31:0] i_Addr;
    logic [31:0] i_StoreData;
    logic [31:0] i_AluData;
    logic [4:0]  i_RdAddr;
    logic        i_WriteEn;
    logic        i_FlushEn;
    logic [31:0] o_dMem_Addr;
    logic [31:0] o_dMem_DataWrite;
    logic [3:0]  o_dMem_ByteEn;
    logic        o_dMem_ReadEn;
    logic        o_dMem_WriteEn;
    logic [31:0] i_dMem_DataRead;
    logic        i_dMem_Ready;
    logic        o_WbEn;
    logic [4:0]  o_WbAddr;
    logic [31:0] o_WbData;
    logic        o_StallEn;
    logic        o_Exception;
    logic [1:0]  o_ExcCause;
    logic [31:0] o_ExcAddr;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] rdata;
        int          delay;
        int          kind;
        logic [1:0]  cause;
        logic [31:0] baddr;
        logic [3:0]  ben;
        logic [31:0] dwr;
        logic        wb;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[19];
    vec_t sb[$];
    int   nChecks = 0;
    int   nPassed = 0;

    core_lsu dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i_Valid          (i_Valid),
        .i_Load           (i_Load),
        .i_Store          (i_Store),
        .i_Funct3         (i_Funct3),
        .i_Addr           (i_Addr),
        .i_StoreData      (i_StoreData),
        .i_AluData        (i_AluData),
        .i_RdAddr         (i_RdAddr),
        .i_WriteEn        (i_WriteEn),
        .i_FlushEn        (i_FlushEn),
        .o_dMem_Addr      (o_dMem_Addr),
        .o_dMem_DataWrite (o_dMem_DataWrite),
        .o_dMem_ByteEn    (o_dMem_ByteEn),
        .o_dMem_ReadEn    (o_dMem_ReadEn),
        .o_dMem_WriteEn   (o_dMem_WriteEn),
        .i_dMem_DataRead  (i_dMem_DataRead),
        .i_dMem_Ready     (i_dMem_Ready),
        .o_WbEn           (o_WbEn),
        .o_WbAddr         (o_WbAddr),
        .o_WbData         (o_WbData),
        .o_StallEn        (o_StallEn),
        .o_Exception      (o_Exception),
        .o_ExcCause       (o_ExcCause),
        .o_ExcAddr        (o_ExcAddr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] alu, input logic [4:0] rd, input logic wen,
                                input logic [31:0] rdata, input int delay, input int kind,
                                input logic [1:0] cause, input logic [31:0] baddr,
                                input logic [3:0] ben, input logic [31:0] dwr,
                                input logic wb, input logic [31:0] wbdata);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.alu = alu;
        v.rd = rd; v.wen = wen; v.rdata = rdata; v.delay = delay; v.kind = kind;
        v.cause = cause; v.baddr = baddr; v.ben = ben; v.dwr = dwr; v.wb = wb; v.wbdata = wbdata;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        else
            nPassed++;
    endtask

    task automatic idleInputs();
        i_Valid     = 1'b0;
        i_Load      = 1'b0;
        i_Store     = 1'b0;
        i_FlushEn   = 1'b0;
        i_dMem_Ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge i_Clk);
        i_Valid     = 1'b1;
        i_Load      = v.ld;
        i_Store     = v.st;
        i_Funct3    = v.f3;
        i_Addr      = v.addr;
        i_StoreData = v.sdata;
        i_AluData   = v.alu;
        i_RdAddr    = v.rd;
        i_WriteEn   = v.wen;
        i_FlushEn   = 1'b0;
        sb.push_back(v);
    endtask

    task automatic cycle();
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic runCheck(input int idx);
        vec_t e;
        string p;
        if (sb.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL v%0d scoreboard: got empty queue, expected one entry", idx);
            return;
        end
        e = sb.pop_front();
        p = $sformatf("v%0d", idx);
        if (e.kind == KIND_ALU) begin
            checkOutput({p, " wbEn"}, o_WbEn, e.wb);
            if (e.wb) begin
                checkOutput({p, " wbAddr"}, o_WbAddr, e.rd);
                checkOutput({p, " wbData"}, o_WbData, e.wbdata);
            end
            checkOutput({p, " stall"}, o_StallEn, 0);
            checkOutput({p, " readEn"}, o_dMem_ReadEn, 0);
            cycle();
            checkOutput({p, " wbEn pulse"}, o_WbEn, 0);
        end else if (e.kind == KIND_EXC) begin
            checkOutput({p, " exception"}, o_Exception, 1);
            checkOutput({p, " cause"}, o_ExcCause, e.cause);
            checkOutput({p, " excAddr"}, o_ExcAddr, e.addr);
            checkOutput({p, " busEn"}, {o_dMem_ReadEn, o_dMem_WriteEn}, 0);
            checkOutput({p, " wbEn"}, o_WbEn, 0);
            checkOutput({p, " stall"}, o_StallEn, 0);
            cycle();
            checkOutput({p, " exception pulse"}, o_Exception, 0);
        end else begin
            checkOutput({p, " stall"}, o_StallEn, 1);
            checkOutput({p, " readEn"}, o_dMem_ReadEn, e.ld);
            checkOutput({p, " writeEn"}, o_dMem_WriteEn, e.st);
            checkOutput({p, " busAddr"}, o_dMem_Addr, e.baddr);
            checkOutput({p, " byteEn"}, o_dMem_ByteEn, e.ben);
            if (e.st)
                checkOutput({p, " dataWrite"}, o_dMem_DataWrite, e.dwr);
            // Unrelated ops presented while busy must not disturb the bus request.
            for (int c = 0; c < e.delay; c++) begin
                i_Valid     = 1'b1;
                i_Store     = 1'b1;
                i_Funct3    = 3'b010;
                i_Addr      = $urandom;
                i_StoreData = $urandom;
                cycle();
                checkOutput({p, " busy stall"}, o_StallEn, 1);
                checkOutput({p, " busy addr"}, o_dMem_Addr, e.baddr);
                checkOutput({p, " busy en"}, {o_dMem_ReadEn, o_dMem_WriteEn}, {e.ld, e.st});
                checkOutput({p, " busy wbEn"}, o_WbEn, 0);
            end
            i_dMem_DataRead = e.rdata;
            i_dMem_Ready    = 1'b1;
            cycle();
            idleInputs();
            i_dMem_DataRead = 32'h0;
            checkOutput({p, " done en"}, {o_dMem_ReadEn, o_dMem_WriteEn}, 0);
            checkOutput({p, " done stall"}, o_StallEn, 0);
            checkOutput({p, " wbEn"}, o_WbEn, e.wb);
            if (e.wb) begin
                checkOutput({p, " wbAddr"}, o_WbAddr, e.rd);
                checkOutput({p, " wbData"}, o_WbData, e.wbdata);
            end
            cycle();
            checkOutput({p, " wbEn pulse"}, o_WbEn, 0);
        end
    endtask

    initial begin
        vecs[0]  = mk(0,1,3'b010,32'h100,32'hDEADBEEF,0,5'd3,0,0,1,KIND_MEM,0,32'h100,4'hF,32'hDEADBEEF,0,0);
        vecs[1]  = mk(1,0,3'b000,32'h203,0,0,5'd5,0,32'h80FF0000,0,KIND_MEM,0,32'h200,4'h8,0,1,32'hFFFFFF80);
        vecs[2]  = mk(1,0,3'b100,32'h203,0,0,5'd5,0,32'h80FF0000,0,KIND_MEM,0,32'h200,4'h8,0,1,32'h00000080);
        vecs[3]  = mk(0,1,3'b001,32'h302,32'h1234ABCD,0,5'd0,0,0,0,KIND_MEM,0,32'h300,4'hC,32'hABCDABCD,0,0);
        vecs[4]  = mk(1,0,3'b001,32'h202,0,0,5'd6,0,32'h80FF0000,2,KIND_MEM,0,32'h200,4'hC,0,1,32'hFFFF80FF);
        vecs[5]  = mk(1,0,3'b101,32'h200,0,0,5'd11,0,32'h80FF8001,0,KIND_MEM,0,32'h200,4'h3,0,1,32'h00008001);
        vecs[6]  = mk(1,0,3'b010,32'h400,0,0,5'd8,0,32'h12345678,3,KIND_MEM,0,32'h400,4'hF,0,1,32'h12345678);
        vecs[7]  = mk(0,1,3'b000,32'h101,32'h000000A5,0,5'd2,0,0,0,KIND_MEM,0,32'h100,4'h2,32'hA5A5A5A5,0,0);
        vecs[8]  = mk(1,0,3'b000,32'h000,0,0,5'd0,0,32'h0000007F,0,KIND_MEM,0,32'h000,4'h1,0,0,0);
        vecs[9]  = mk(0,0,3'b000,32'h0,0,32'h55,5'd7,1,0,0,KIND_ALU,0,0,0,0,1,32'h55);
        vecs[10] = mk(0,0,3'b000,32'h0,0,32'h99,5'd0,1,0,0,KIND_ALU,0,0,0,0,0,0);
        vecs[11] = mk(0,0,3'b000,32'h0,0,32'h66,5'd7,0,0,0,KIND_ALU,0,0,0,0,0,0);
        vecs[12] = mk(1,0,3'b011,32'h500,0,0,5'd4,0,0,0,KIND_EXC,2'b11,0,0,0,0,0);
        vecs[13] = mk(0,1,3'b100,32'h504,0,0,5'd4,0,0,0,KIND_EXC,2'b11,0,0,0,0,0);
        vecs[14] = mk(1,1,3'b010,32'h508,0,0,5'd4,0,0,0,KIND_EXC,2'b11,0,0,0,0,0);
        vecs[15] = mk(1,0,3'b110,32'h50C,0,0,5'd4,0,0,0,KIND_EXC,2'b11,0,0,0,0,0);
`ifdef KAYRV32_MISALIGN_TRAP_EN
        vecs[16] = mk(1,0,3'b010,32'h401,0,0,5'd12,0,32'hCAFEF00D,0,KIND_EXC,2'b01,0,0,0,0,0);
        vecs[17] = mk(0,1,3'b001,32'h303,32'h1234ABCD,0,5'd0,0,0,0,KIND_EXC,2'b10,0,0,0,0,0);
`else
        vecs[16] = mk(1,0,3'b010,32'h401,0,0,5'd12,0,32'hCAFEF00D,0,KIND_MEM,0,32'h400,4'hF,0,1,32'hCAFEF00D);
        vecs[17] = mk(0,1,3'b001,32'h303,32'h1234ABCD,0,5'd0,0,0,1,KIND_MEM,0,32'h300,4'hC,32'hABCDABCD,0,0);
`endif
        vecs[18] = mk(1,0,3'b000,32'h202,0,0,5'd13,0,32'h00127F00,0,KIND_MEM,0,32'h200,4'h4,0,1,32'h00000012);

        idleInputs();
        i_Rst = 1'b1;
        i_Funct3 = 3'b000; i_Addr = 0; i_StoreData = 0; i_AluData = 0;
        i_RdAddr = 0; i_WriteEn = 0; i_dMem_DataRead = 0;
        repeat (3) cycle();
        checkOutput("reset stall", o_StallEn, 0);
        checkOutput("reset busEn", {o_dMem_ReadEn, o_dMem_WriteEn}, 0);
        checkOutput("reset busAddr", o_dMem_Addr, 0);
        checkOutput("reset byteEn", o_dMem_ByteEn, 0);
        checkOutput("reset wbEn", o_WbEn, 0);
        checkOutput("reset exception", o_Exception, 0);
        i_Rst = 1'b0;

        $display("[TB] running %0d table vectors", 19);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            cycle();
            i_Valid = 1'b0; i_Load = 1'b0; i_Store = 1'b0;
            runCheck(i);
        end

        $display("[TB] reset during busy load");
        applyStimulus(mk(1,0,3'b010,32'h600,0,0,5'd9,0,0,0,KIND_MEM,0,32'h600,4'hF,0,0,0));
        void'(sb.pop_front());
        cycle();
        idleInputs();
        checkOutput("rstbusy readEn before", o_dMem_ReadEn, 1);
        i_Rst = 1'b1;
        cycle();
        checkOutput("rstbusy readEn", o_dMem_ReadEn, 0);
        checkOutput("rstbusy stall", o_StallEn, 0);
        checkOutput("rstbusy busAddr", o_dMem_Addr, 0);
        i_Rst = 1'b0;
        i_dMem_Ready = 1'b1;
        i_dMem_DataRead = 32'h11111111;
        cycle();
        i_dMem_Ready = 1'b0;
        checkOutput("rstbusy wbEn", o_WbEn, 0);
        checkOutput("rstbusy readEn after", o_dMem_ReadEn, 0);
        cycle();
        checkOutput("rstbusy wbEn late", o_WbEn, 0);

        $display("[TB] first op accepted right after reset release");
        i_Rst = 1'b1;
        cycle();
        i_Rst = 1'b0;
        i_Valid = 1'b1; i_Load = 1'b0; i_Store = 1'b0;
        i_RdAddr = 5'd4; i_AluData = 32'h77; i_WriteEn = 1'b1;
        cycle();
        idleInputs();
        checkOutput("postrst wbEn", o_WbEn, 1);
        checkOutput("postrst wbData", o_WbData, 32'h77);

        $display("[TB] flush during busy load");
        applyStimulus(mk(1,0,3'b010,32'h700,0,0,5'd10,0,0,0,KIND_MEM,0,32'h700,4'hF,0,0,0));
        void'(sb.pop_front());
        cycle();
        idleInputs();
        i_FlushEn = 1'b1;
        cycle();
        i_FlushEn = 1'b0;
        checkOutput("flushbusy readEn held", o_dMem_ReadEn, 1);
        checkOutput("flushbusy stall", o_StallEn, 1);
        i_dMem_Ready = 1'b1;
        i_dMem_DataRead = 32'h22222222;
        cycle();
        i_dMem_Ready = 1'b0;
        checkOutput("flushbusy readEn done", o_dMem_ReadEn, 0);
        checkOutput("flushbusy wbEn", o_WbEn, 0);

        $display("[TB] flush on idle store");
        applyStimulus(mk(0,1,3'b010,32'h800,32'h1,0,5'd0,0,0,0,KIND_MEM,0,0,0,0,0,0));
        void'(sb.pop_front());
        i_FlushEn = 1'b1;
        cycle();
        idleInputs();
        checkOutput("flushidle writeEn", o_dMem_WriteEn, 0);
        checkOutput("flushidle stall", o_StallEn, 0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have port i_Clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port i_Rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports i_Valid/i_Load/i_Store, input, 1 each, EX-stage op valid / is load / is store.
REQ-004 SHALL have ports i_Funct3 (3), i_Addr (32), i_StoreData (32), i_AluData (32), i_RdAddr (5), i_WriteEn (1), inputs: access width, effective address, store data, ALU result, destination register, non-memory writeback request.
REQ-005 SHALL have port i_FlushEn, input, 1, discard current/pending op.
REQ-006 SHALL have ports o_dMem_Addr (32), o_dMem_DataWrite (32), o_dMem_ByteEn (4), o_dMem_ReadEn (1), o_dMem_WriteEn (1), outputs, data bus request.
REQ-007 SHALL have ports i_dMem_DataRead (32), i_dMem_Ready (1), inputs, bus read data and completion.
REQ-008 SHALL have ports o_WbEn (1), o_WbAddr (5), o_WbData (32), outputs, to WB stage.
REQ-009 SHALL have ports o_StallEn (1), o_Exception (1), o_ExcCause (2), o_ExcAddr (32), outputs.

Function
REQ-010 SHALL implement FSM IDLE/BUSY; o_StallEn = (state==BUSY), combinational.
REQ-011 In IDLE, i_Valid & (i_Load|i_Store) & ~i_FlushEn & no exception at edge N SHALL enter BUSY and assert ReadEn (load) or WriteEn (store) from N+1.
REQ-012 In BUSY, inputs i_Valid etc. SHALL be ignored; bus signals SHALL stay constant until i_dMem_Ready sampled high.
REQ-013 Ready high at edge M in BUSY SHALL return IDLE, deassert bus enables at M+1; load result SHALL appear with o_WbEn=1 for exactly cycle M+1 (minimum load latency 2 cycles).
REQ-014 o_dMem_Addr SHALL be {i_Addr[31:2],2'b00}.
REQ-015 Stores: SB ByteEn=0001<<Addr[1:0], byte replicated on 4 lanes; SH ByteEn=0011 or 1100 by Addr[1], halfword replicated; SW ByteEn=1111.
REQ-016 Loads: Funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; lane selected by Addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; ByteEn as for stores.
REQ-017 Stores and loads with i_RdAddr==0 SHALL produce o_WbEn=0.
REQ-018 Non-memory op (i_Valid, no load/store) in IDLE SHALL present o_WbEn=i_WriteEn&(RdAddr!=0), o_WbData=i_AluData at N+1.
REQ-019 Funct3 011/110/111 on load, or 011+ on store, SHALL pulse o_Exception at N+1, cause 11, no bus request.
REQ-020 o_Exception SHALL be a one-cycle pulse with o_ExcAddr=i_Addr; no o_WbEn in that cycle.
REQ-021 i_FlushEn in BUSY SHALL NOT abort the bus cycle; transaction completes on Ready but o_WbEn SHALL be suppressed.
REQ-022 i_Load and i_Store both high SHALL be treated as illegal (cause 11).

Reset
REQ-023 i_Rst SHALL force IDLE and all outputs 0 at the next edge, including mid-transaction; a pending Ready is dropped.
REQ-024 After reset release, first op SHALL be accepted on the first edge.

Configuration
REQ-025 With KAYRV32_MISALIGN_TRAP_EN defined, LH/LHU/SH with Addr[0]=1 or LW/SW with Addr[1:0]!=0 SHALL raise exception, cause 01 (load) or 10 (store), no bus request.
REQ-026 Without KAYRV32_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed with offending low address bits forced to 0; causes 01/10 never occur.

Verification
REQ-027 SW Addr=0x100 data 0xDEADBEEF, Ready at 2nd BUSY cycle -> WriteEn 2 cycles, ByteEn=1111, Addr=0x100, Stall 2 cycles, no WbEn.
REQ-028 LB Addr=0x203, rd=5, DataRead=0x80FF_0000, Ready immediate -> WbEn at N+2, WbAddr=5, WbData=0xFFFFFF80; LBU -> 0x00000080.
REQ-029 SH Addr=0x302 data 0x1234ABCD -> ByteEn=1100, DataWrite=0xABCDABCD.
REQ-030 LW Addr=0x401 with macro -> Exception cause 01, ExcAddr=0x401, no ReadEn; without macro -> ReadEn, Addr=0x400.
REQ-031 i_Rst asserted during BUSY, then Ready -> ReadEn 0 next edge, no WbEn ever; i_FlushEn during BUSY -> bus completes, WbEn stays 0.
REQ-032 ALU op rd=7 data 0x55 in IDLE -> WbEn=1, WbData=0x55 at N+1, Stall never asserted.
